// File: rtl/mem_access_unit.sv
// RV32I load/store access unit: takes one request from the control unit,
// runs one memory handshake with a timeout, returns aligned/extended data.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   logic        legal, misalign;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic [31:0] byte_sh, ld_data;
   logic [15:0] lane_h;

   // Decode of the incoming request: legality, alignment, lanes, store data.
   always_comb begin
      legal    = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misalign = 1'b0;
      be_in    = 4'b1111;
      wdata_in = req_wdata;
      unique case (req_funct3[1:0])
         2'b00: begin
            be_in    = 4'b0001 << req_addr[1:0];
            wdata_in = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misalign = req_addr[0];
            be_in    = 4'b0011 << {req_addr[1], 1'b0};
            wdata_in = {2{req_wdata[15:0]}};
         end
         2'b10: misalign = |req_addr[1:0];
         default: ;
      endcase
   end

   // Load lane select and sign/zero extension.
   always_comb begin
      byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
      lane_h  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (f3_q)
         3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_data = {24'd0, byte_sh[7:0]};
         3'b101:  ld_data = {16'd0, lane_h};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               we_d    = req_write;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               be_d    = be_in;
               wdata_d = wdata_in;
               if (legal && !misalign) begin
                  state_d = ACCESS;
                  cnt_d   = '0;
               end else begin
                  state_d = RESP;
                  fault_d = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ACCESS: begin
            // An ack in the timeout cycle wins over the timeout.
            if (mem_ack) begin
               state_d = RESP;
               fault_d = 1'b0;
               rdata_d = we_q ? '0 : ld_data;
            end else if (cnt_q == TO_LIM) begin
               state_d = RESP;
               fault_d = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Registered so ready stays low while reset is held and rises one edge later.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_fault = fault_q;
   assign mem_req    = (state_q == ACCESS);
   assign mem_we     = (state_q == ACCESS) && we_q;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand sequences for
// reset/stray-ack corners, and random traffic against a reference model.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          k;      // ACCESS cycle carrying mem_ack; 0 or >TO = never
      logic [31:0] rd;
   } txn_t;

   typedef struct {
      logic        imm;    // faults at acceptance, no memory access
      logic        fault;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s got=%h want=%h", nm, what, act, exp);
      end
   endtask

   // Reference: derived from access size and byte offset with plain arithmetic.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      int sz, off;
      logic [31:0] mask, v;
      sz  = 1 << t.f3[1:0];
      off = int'(t.a % 4);
      e.imm = (t.f3[1:0] == 2'b11) || (t.w && t.f3[2]) || (!t.w && t.f3 == 3'b110)
              || (off % sz != 0);
      e.be = (sz >= 4) ? 4'hF : 4'(((1 << sz) - 1) << off);
      e.wd = (sz == 1) ? {4{t.wd[7:0]}} : (sz == 2) ? {2{t.wd[15:0]}} : t.wd;
      e.fault = e.imm || t.k < 1 || t.k > TO;
      e.rd = '0;
      if (!e.fault && !t.w) begin
         v    = t.rd >> (8 * off);
         mask = (sz >= 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
         v    = v & mask;
         if (!t.f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
         e.rd = v;
      end
      return e;
   endfunction

   function automatic vec_t mkv(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int k, input logic [31:0] rd,
                                input logic imm, input logic fault, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd);
      vec_t v;
      v.t = '{w: w, f3: f3, a: a, wd: wd, k: k, rd: rd};
      v.e = '{imm: imm, fault: fault, be: be, wd: ewd, rd: erd};
      return v;
   endfunction

   // Called at a negedge with the unit idle; returns at a negedge back in IDLE.
   task automatic run_txn(input txn_t t, input exp_t e, input string nm);
      int c;
      chk(nm, "ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = t.w; req_funct3 = t.f3; req_addr = t.a; req_wdata = t.wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = $urandom; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      if (e.imm) begin
         @(negedge clk);
         chk(nm, "resp_valid", 32'(resp_valid), 32'd1);
         chk(nm, "resp_fault", 32'(resp_fault), 32'd1);
         chk(nm, "resp_rdata", resp_rdata, 32'd0);
         chk(nm, "mem_req", 32'(mem_req), 32'd0);
      end else begin
         c = 1;
         forever begin
            @(negedge clk);
            chk(nm, "mem_req", 32'(mem_req), 32'd1);
            chk(nm, "mem_be", 32'(mem_be), 32'(e.be));
            chk(nm, "mem_we", 32'(mem_we), 32'(t.w));
            chk(nm, "mem_addr", mem_addr, {t.a[31:2], 2'b00});
            if (t.w) chk(nm, "mem_wdata", mem_wdata, e.wd);
            if (c == t.k) begin mem_ack = 1'b1; mem_rdata = t.rd; end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (c == t.k || c == TO) break;
            c++;
         end
         @(negedge clk);
         chk(nm, "resp_valid", 32'(resp_valid), 32'd1);
         chk(nm, "resp_fault", 32'(resp_fault), 32'(e.fault));
         chk(nm, "resp_rdata", resp_rdata, e.rd);
         chk(nm, "mem_req_off", 32'(mem_req), 32'd0);
      end
      @(negedge clk);
      chk(nm, "resp_valid_drop", 32'(resp_valid), 32'd0);
      chk(nm, "ready_back", 32'(req_ready), 32'd1);
      chk(nm, "fault_hold", 32'(resp_fault), 32'(e.fault));
      chk(nm, "rdata_hold", resp_rdata, e.rd);
   endtask

   vec_t tbl[14];

   initial begin
      txn_t t;
      exp_t e;
      tbl[0]  = mkv(0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF);
      tbl[1]  = mkv(0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80);
      tbl[2]  = mkv(0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF0000, 0, 0, 4'h8, 32'h0, 32'h00000080);
      tbl[3]  = mkv(1, 3'b001, 32'h102, 32'h1234ABCD, 1, 32'h0, 0, 0, 4'hC, 32'hABCDABCD, 32'h0);
      tbl[4]  = mkv(0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
      tbl[5]  = mkv(1, 3'b011, 32'h0, 32'h55, 1, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
      tbl[6]  = mkv(0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 0, 1, 4'hF, 32'h0, 32'h0);
      tbl[7]  = mkv(0, 3'b010, 32'h10, 32'h0, 4, 32'h01234567, 0, 0, 4'hF, 32'h0, 32'h01234567);
      tbl[8]  = mkv(0, 3'b001, 32'h202, 32'h0, 2, 32'h80011234, 0, 0, 4'hC, 32'h0, 32'hFFFF8001);
      tbl[9]  = mkv(1, 3'b000, 32'h301, 32'h7788995A, 1, 32'h0, 0, 0, 4'h2, 32'h5A5A5A5A, 32'h0);
      tbl[10] = mkv(0, 3'b110, 32'h40, 32'h0, 1, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
      tbl[11] = mkv(0, 3'b101, 32'h001, 32'h0, 1, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
      tbl[12] = mkv(0, 3'b101, 32'h000, 32'h0, 1, 32'h1234F00D, 0, 0, 4'h3, 32'h0, 32'h0000F00D);
      tbl[13] = mkv(1, 3'b010, 32'h44, 32'hCAFEF00D, 2, 32'h0, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0);

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset", "req_ready", 32'(req_ready), 32'd0);
      chk("reset", "resp_valid", 32'(resp_valid), 32'd0);
      chk("reset", "resp_rdata", resp_rdata, 32'd0);
      chk("reset", "resp_fault", 32'(resp_fault), 32'd0);
      chk("reset", "mem_req", 32'(mem_req), 32'd0);
      chk("reset", "mem_we", 32'(mem_we), 32'd0);
      chk("reset", "mem_addr", mem_addr, 32'd0);
      chk("reset", "mem_be", 32'(mem_be), 32'd0);
      chk("reset", "mem_wdata", mem_wdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("release", "req_ready", 32'(req_ready), 32'd1);

      foreach (tbl[i]) run_txn(tbl[i].t, tbl[i].e, $sformatf("vec%0d", i));

      // Stray acks while idle must not start or complete anything.
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      repeat (2) begin
         @(negedge clk);
         chk("stray_ack", "resp_valid", 32'(resp_valid), 32'd0);
         chk("stray_ack", "req_ready", 32'(req_ready), 32'd1);
         chk("stray_ack", "mem_req", 32'(mem_req), 32'd0);
      end
      mem_ack = 1'b0;

      // Reset in the middle of an access.
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid", "mem_req_before", 32'(mem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid", "mem_req_async", 32'(mem_req), 32'd0);
      chk("rst_mid", "resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mid", "req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      chk("rst_mid", "ready_at_release", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rst_mid", "ready_after", 32'(req_ready), 32'd1);
      chk("rst_mid", "resp_valid_after", 32'(resp_valid), 32'd0);
      chk("rst_mid", "mem_req_after", 32'(mem_req), 32'd0);

      for (int i = 0; i < 150; i++) begin
         t.w  = 1'($urandom);
         t.f3 = 3'($urandom);
         t.a  = $urandom;
         t.wd = $urandom;
         t.k  = $urandom_range(0, 5);
         t.rd = $urandom;
         e = model(t);
         run_txn(t, e, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
